// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - UART transmit framer with one-entry holding buffer
// Frames are start, DATA_WIDTH data bits LSB-first, optional parity, one or two stops.

module uart_tx_framer #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  baud_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  data_valid,
   output logic                  data_ready,
   input  logic                  par_en,
   input  logic                  par_odd,
   input  logic                  two_stop,
   output logic                  tx_out,
   output logic                  busy,
   output logic                  frame_done
);

   localparam int CW = $clog2(DATA_WIDTH + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
   } state_t;

   state_t                state_q, state_d;
   logic                  buf_full_q, buf_full_d;
   logic [DATA_WIDTH-1:0] buf_data_q;
   logic                  buf_par_en_q, buf_par_odd_q, buf_two_stop_q;
   logic [DATA_WIDTH:0]   sh_q, sh_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  par_en_q, par_en_d;
   logic                  two_stop_q, two_stop_d;
   logic                  tx_q, tx_d;
   logic                  done_q, done_d;
   logic                  hs, frame_end, load, par_bit;

   assign hs        = data_valid && !buf_full_q;
   assign frame_end = baud_en && ((state_q == S_STOP1 && !two_stop_q) || state_q == S_STOP2);
   assign load      = baud_en && buf_full_q && (state_q == S_IDLE || frame_end);
   assign par_bit   = buf_par_odd_q ? ~^buf_data_q : ^buf_data_q;

   // A drain needs a full buffer and a write needs an empty one, so they never collide.
   always_comb begin
      buf_full_d = buf_full_q;
      if (load)
         buf_full_d = 1'b0;
      else if (hs)
         buf_full_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         buf_full_q <= 1'b0;
      end else begin
         buf_full_q <= buf_full_d;
         if (hs) begin
            buf_data_q     <= data_in;
            buf_par_en_q   <= par_en;
            buf_par_odd_q  <= par_odd;
            buf_two_stop_q <= two_stop;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         sh_q       <= '1;
         cnt_q      <= '0;
         par_en_q   <= 1'b0;
         two_stop_q <= 1'b0;
         tx_q       <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sh_q       <= sh_d;
         cnt_q      <= cnt_d;
         par_en_q   <= par_en_d;
         two_stop_q <= two_stop_d;
         tx_q       <= tx_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (baud_en) begin
         case (state_q)
            S_IDLE:   if (buf_full_q) state_d = S_START;
            S_START:  state_d = S_DATA;
            S_DATA:   if (cnt_q == LAST_CNT) state_d = par_en_q ? S_PARITY : S_STOP1;
            S_PARITY: state_d = S_STOP1;
            S_STOP1:  state_d = two_stop_q ? S_STOP2 : (buf_full_q ? S_START : S_IDLE);
            S_STOP2:  state_d = buf_full_q ? S_START : S_IDLE;
            default:  state_d = S_IDLE;
         endcase
      end
   end

   // The shift register holds {parity, data}; after DATA_WIDTH shifts the parity sits in bit 0.
   always_comb begin
      sh_d       = sh_q;
      cnt_d      = cnt_q;
      par_en_d   = par_en_q;
      two_stop_d = two_stop_q;
      tx_d       = tx_q;
      done_d     = frame_end;
      if (load) begin
         sh_d       = {par_bit, buf_data_q};
         cnt_d      = '0;
         par_en_d   = buf_par_en_q;
         two_stop_d = buf_two_stop_q;
         tx_d       = 1'b0;
      end else if (baud_en) begin
         case (state_q)
            S_START: begin
               tx_d  = sh_q[0];
               sh_d  = {1'b1, sh_q[DATA_WIDTH:1]};
               cnt_d = CW'(1);
            end
            S_DATA: begin
               if (cnt_q != LAST_CNT) begin
                  tx_d  = sh_q[0];
                  sh_d  = {1'b1, sh_q[DATA_WIDTH:1]};
                  cnt_d = cnt_q + CW'(1);
               end else begin
                  tx_d = par_en_q ? sh_q[0] : 1'b1;
               end
            end
            default: tx_d = 1'b1;
         endcase
      end
   end

   assign data_ready = !buf_full_q;
   assign tx_out     = tx_q;
   assign busy       = (state_q != S_IDLE);
   assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb/tb_uart_tx_framer.sv - self-checking bench for uart_tx_framer
// Line bits are captured at each baud edge and decoded into frames for comparison.

module tb_uart_tx_framer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1;
   logic       baud_en = 1'b0;
   logic [7:0] data8 = '0;
   logic [6:0] data7 = '0;
   logic       valid8 = 1'b0, valid7 = 1'b0;
   logic       par_en = 1'b0, par_odd = 1'b0, two_stop = 1'b0;
   logic       ready8, tx8, busy8, fdone8;
   logic       ready7, tx7, busy7, fdone7;

   uart_tx_framer #(.DATA_WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .baud_en(baud_en), .data_in(data8), .data_valid(valid8),
      .data_ready(ready8), .par_en(par_en), .par_odd(par_odd), .two_stop(two_stop),
      .tx_out(tx8), .busy(busy8), .frame_done(fdone8));

   uart_tx_framer #(.DATA_WIDTH(7)) dut7 (
      .clk(clk), .rst(rst), .baud_en(baud_en), .data_in(data7), .data_valid(valid7),
      .data_ready(ready7), .par_en(par_en), .par_odd(par_odd), .two_stop(two_stop),
      .tx_out(tx7), .busy(busy7), .frame_done(fdone7));

   typedef struct {
      logic [8:0]  d;
      logic        pe, po, ts;
      int          len;
      logic [0:12] bits;
   } vec_t;

   typedef struct {
      logic [8:0] d;
      logic       pe, po, ts;
   } cfg_t;

   int   checks = 0, errors = 0;
   int   auto_div = 0, phase = 0;
   int   done8 = 0, done7 = 0, busy8_cnt = 0;
   logic rx8[$];
   logic rx7[$];

   vec_t        vt[8];
   cfg_t        cq[$];
   cfg_t        cf;
   logic [0:12] g, e;
   int          sk, len, d0, b0, bad, s0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic cyc();
      if (auto_div != 0) begin
         baud_en = (phase == 0);
         phase   = (phase + 1) % auto_div;
      end
      @(posedge clk);
      #1;
      if (baud_en) begin
         rx8.push_back(tx8);
         rx7.push_back(tx7);
      end
      if (fdone8) done8++;
      if (fdone7) done7++;
      if (busy8) busy8_cnt++;
   endtask

   task automatic set_div(input int d);
      auto_div = d;
      phase    = 0;
      if (d == 0) baud_en = 1'b0;
   endtask

   task automatic tick();
      baud_en = 1'b1;
      cyc();
      baud_en = 1'b0;
   endtask

   // Holds the word until accepted, then scrambles the inputs to prove they were captured.
   task automatic send(input int sel, input logic [8:0] d, input logic pe, input logic po,
                       input logic ts);
      int   n;
      logic rdy;
      par_en = pe; par_odd = po; two_stop = ts;
      if (sel == 0) begin data8 = d[7:0]; valid8 = 1'b1; end
      else          begin data7 = d[6:0]; valid7 = 1'b1; end
      for (n = 0; n < 3000; n++) begin
         rdy = (sel == 0) ? ready8 : ready7;
         cyc();
         if (rdy) break;
      end
      valid8 = 1'b0; valid7 = 1'b0;
      data8 = 8'($urandom); data7 = 7'($urandom);
      par_en = 1'($urandom); par_odd = 1'($urandom); two_stop = 1'($urandom);
      chk("send_handshake", 32'(n < 3000), 1);
   endtask

   task automatic get_frame(input int sel, input int flen, output logic [0:12] got,
                            output int skipped);
      int   n, c;
      logic b;
      n = 0; skipped = 0; got = '1;
      for (c = 0; c < 2000; c++) begin
         while (n < flen && ((sel == 0) ? rx8.size() : rx7.size()) > 0) begin
            if (sel == 0) b = rx8.pop_front();
            else          b = rx7.pop_front();
            if (n == 0 && b === 1'b1) skipped++;
            else begin
               got[n] = b;
               n++;
            end
         end
         if (n == flen) break;
         cyc();
      end
      chk("frame_complete", 32'(n == flen), 1);
   endtask

   task automatic wait_idle();
      int c;
      for (c = 0; c < 300; c++) begin
         if (!busy8 && !busy7) break;
         cyc();
      end
      chk("idle_reached", 32'(busy8 | busy7), 0);
   endtask

   task automatic wait_busy8();
      int c;
      for (c = 0; c < 50; c++) begin
         if (busy8) break;
         cyc();
      end
      chk("busy_rise", 32'(busy8), 1);
   endtask

   function automatic void model(input int dw, input logic [8:0] d, input logic pe,
                                 input logic po, input logic ts,
                                 output logic [0:12] bits, output int flen);
      int ones;
      ones = 0;
      bits = '1;
      bits[0] = 1'b0;
      for (int i = 0; i < dw; i++) begin
         bits[1 + i] = d[i];
         if (d[i]) ones++;
      end
      flen = 1 + dw;
      if (pe) begin
         bits[flen] = ((ones % 2) == 1) ^ po;
         flen++;
      end
      flen = flen + 1 + (ts ? 1 : 0);
   endfunction

   initial begin : main
      vt[0] = '{9'hA5, 1'b0, 1'b0, 1'b0, 10, 13'b0101001011111};
      vt[1] = '{9'hA5, 1'b1, 1'b0, 1'b0, 11, 13'b0101001010111};
      vt[2] = '{9'hA5, 1'b1, 1'b1, 1'b0, 11, 13'b0101001011111};
      vt[3] = '{9'h00, 1'b0, 1'b0, 1'b0, 10, 13'b0000000001111};
      vt[4] = '{9'hFF, 1'b0, 1'b0, 1'b0, 10, 13'b0111111111111};
      vt[5] = '{9'hFF, 1'b1, 1'b0, 1'b1, 12, 13'b0111111110111};
      vt[6] = '{9'h01, 1'b1, 1'b1, 1'b1, 12, 13'b0100000000111};
      vt[7] = '{9'h80, 1'b1, 1'b0, 1'b0, 11, 13'b0000000011111};

      // Reset, with a write attempt that must be ignored.
      valid8 = 1'b1; data8 = 8'hFF;
      cyc(); cyc();
      chk("rst_ready", 32'(ready8), 1);
      chk("rst_tx", 32'(tx8), 1);
      chk("rst_busy", 32'(busy8), 0);
      chk("rst_done", 32'(fdone8), 0);
      valid8 = 1'b0; rst = 1'b0;
      cyc();
      chk("post_rst_ready", 32'(ready8), 1);

      // Table of known frames at baud every 4 clks.
      set_div(4);
      foreach (vt[i]) begin
         rx8.delete();
         d0 = done8; b0 = busy8_cnt;
         send(0, vt[i].d, vt[i].pe, vt[i].po, vt[i].ts);
         get_frame(0, vt[i].len, g, sk);
         chk($sformatf("vec%0d_bits", i), 32'(g), 32'(vt[i].bits));
         wait_idle();
         chk($sformatf("vec%0d_done", i), 32'(done8 - d0), 1);
         chk($sformatf("vec%0d_busy_clks", i), 32'(busy8_cnt - b0), 32'(vt[i].len * 4));
      end

      // Seven-bit word, odd parity, two stops.
      rx7.delete(); d0 = done7;
      send(1, 9'h55, 1'b1, 1'b1, 1'b1);
      get_frame(1, 11, g, sk);
      chk("dw7_bits", 32'(g), 32'(13'b0101010111111));
      wait_idle();
      chk("dw7_done", 32'(done7 - d0), 1);

      // Back-to-back frames with the second word buffered mid-frame.
      rx8.delete(); d0 = done8;
      send(0, 9'h00, 1'b0, 1'b0, 1'b0);
      wait_busy8();
      send(0, 9'hFF, 1'b0, 1'b0, 1'b0);
      bad = 0;
      for (int c = 0; c < 200; c++) begin
         if (fdone8) break;
         if (ready8) bad++;
         cyc();
      end
      chk("b2b_ready_low", 32'(bad), 0);
      chk("b2b_ready_at_load", 32'(ready8), 1);
      chk("b2b_start_at_end", 32'(tx8), 0);
      get_frame(0, 10, g, sk);
      chk("b2b_f1_bits", 32'(g), 32'(13'b0000000001111));
      get_frame(0, 10, g, sk);
      chk("b2b_f2_bits", 32'(g), 32'(13'b0111111111111));
      chk("b2b_gap", 32'(sk), 0);
      wait_idle();
      chk("b2b_done", 32'(done8 - d0), 2);

      // Handshake on the frame-end edge with an empty buffer: one idle bit, no chaining.
      set_div(0); rx8.delete(); d0 = done8;
      send(0, 9'h3C, 1'b0, 1'b0, 1'b0);
      tick();
      chk("sim_start", 32'(tx8), 0);
      for (int i = 0; i < 9; i++) tick();
      par_en = 1'b0; par_odd = 1'b0; two_stop = 1'b0;
      data8 = 8'hC3; valid8 = 1'b1;
      chk("sim_ready", 32'(ready8), 1);
      baud_en = 1'b1;
      cyc();
      valid8 = 1'b0; baud_en = 1'b0;
      chk("sim_done", 32'(fdone8), 1);
      chk("sim_busy", 32'(busy8), 0);
      chk("sim_tx_idle", 32'(tx8), 1);
      chk("sim_buffered", 32'(ready8), 0);
      cyc(); cyc();
      chk("sim_hold", 32'(tx8), 1);
      tick();
      chk("sim_start2", 32'(tx8), 0);
      set_div(3);
      get_frame(0, 10, g, sk);
      model(8, 9'h3C, 1'b0, 1'b0, 1'b0, e, len);
      chk("sim_f1_bits", 32'(g), 32'(e));
      get_frame(0, 10, g, sk);
      model(8, 9'hC3, 1'b0, 1'b0, 1'b0, e, len);
      chk("sim_f2_bits", 32'(g), 32'(e));
      chk("sim_gap", 32'(sk), 1);
      wait_idle();
      chk("sim_done_cnt", 32'(done8 - d0), 2);

      // Handshake coinciding with a tick, then a long stall of baud_en.
      set_div(0); rx8.delete();
      baud_en = 1'b1;
      send(0, 9'h96, 1'b1, 1'b0, 1'b0);
      baud_en = 1'b0;
      chk("samecyc_tx", 32'(tx8), 1);
      chk("samecyc_busy", 32'(busy8), 0);
      bad = 0;
      for (int c = 0; c < 50; c++) begin
         cyc();
         if (tx8 !== 1'b1 || busy8 !== 1'b0) bad++;
      end
      chk("stall_hold", 32'(bad), 0);
      tick();
      chk("stall_start", 32'(tx8), 0);
      chk("stall_busy", 32'(busy8), 1);
      set_div(2);
      model(8, 9'h96, 1'b1, 1'b0, 1'b0, e, len);
      get_frame(0, len, g, sk);
      chk("stall_bits", 32'(g), 32'(e));
      wait_idle();

      // Reset during data bit 3 with a word buffered.
      set_div(4); d0 = done8;
      send(0, 9'h52, 1'b1, 1'b0, 1'b0);
      wait_busy8();
      s0 = rx8.size();
      send(0, 9'h77, 1'b0, 1'b0, 1'b1);
      for (int c = 0; c < 100; c++) begin
         if (rx8.size() >= s0 + 4) break;
         cyc();
      end
      chk("rst_mid_bit3", 32'(tx8), 0);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("rst_mid_tx", 32'(tx8), 1);
      chk("rst_mid_ready", 32'(ready8), 1);
      chk("rst_mid_busy", 32'(busy8), 0);
      chk("rst_mid_done", 32'(fdone8), 0);
      bad = 0;
      for (int c = 0; c < 80; c++) begin
         cyc();
         if (busy8 || fdone8) bad++;
      end
      chk("rst_mid_quiet", 32'(bad), 0);
      chk("rst_mid_no_done", 32'(done8 - d0), 0);
      rx8.delete();
      send(0, 9'h81, 1'b0, 1'b0, 1'b1);
      model(8, 9'h81, 1'b0, 1'b0, 1'b1, e, len);
      get_frame(0, len, g, sk);
      chk("rst_after_bits", 32'(g), 32'(e));
      wait_idle();
      chk("rst_after_done", 32'(done8 - d0), 1);

      // Random words and frame formats with varying baud rate and gaps.
      rx8.delete(); d0 = done8;
      for (int i = 0; i < 40; i++) begin
         set_div(int'($urandom_range(1, 4)));
         cf.d  = 9'($urandom_range(0, 255));
         cf.pe = 1'($urandom); cf.po = 1'($urandom); cf.ts = 1'($urandom);
         cq.push_back(cf);
         send(0, cf.d, cf.pe, cf.po, cf.ts);
         if ($urandom_range(0, 3) == 0) wait_idle();
         else for (int c = 0; c < int'($urandom_range(0, 20)); c++) cyc();
      end
      set_div(2);
      for (int i = 0; i < 40; i++) begin
         cf = cq.pop_front();
         model(8, cf.d, cf.pe, cf.po, cf.ts, e, len);
         get_frame(0, len, g, sk);
         chk($sformatf("rand%0d_d%0h_p%0d%0d_s%0d", i, cf.d, cf.pe, cf.po, cf.ts),
             32'(g), 32'(e));
      end
      wait_idle();
      chk("rand_done_cnt", 32'(done8 - d0), 40);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
